// File: rtl/branch_resolver.sv
// ============================================================================
// branch_resolver : in-flight branch FIFO that checks predictions at execute,
//                   emits predictor updates and flush/redirect on mispredict.
// Optional: define BR_RESOLVER_STATS_EN for Branch_Count / Mispred_Count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_resolver #(
    parameter int DEPTH = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        F_Valid,
    input  logic        F_Pred,
    input  logic [0:3]  F_Index,
    input  logic [0:31] F_Target,
    input  logic [0:31] F_Fallthru,
    output logic        F_Ready,
    input  logic        E_Valid,
    input  logic        E_Taken,
    output logic [0:1]  pred_actual,
    output logic [0:3]  Upd_Index,
    output logic        Upd_Valid,
    output logic        Flush,
    output logic [0:31] Redirect_PC,
    output logic        Empty,
    output logic        Full,
`ifdef BR_RESOLVER_STATS_EN
    output logic [0:15] Branch_Count,
    output logic [0:15] Mispred_Count,
`endif
    output logic        Underflow
);

    localparam int            AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   c_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);

    logic          r_pred     [DEPTH];
    logic [0:3]    r_index    [DEPTH];
    logic [0:31]   r_target   [DEPTH];
    logic [0:31]   r_fallthru [DEPTH];

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic          r_upd_valid;
    logic          r_flush;
    logic [0:1]    r_pred_actual;
    logic [0:3]    r_upd_index;
    logic [0:31]   r_redirect;
    logic          r_underflow;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_mispred;
    logic          w_head_pred;
    logic [0:3]    w_head_index;
    logic [0:31]   w_head_target;
    logic [0:31]   w_head_fallthru;

    always_comb begin
        w_empty         = (r_count == '0);
        w_full          = (r_count == c_DEPTH);
        w_push          = F_Valid && !w_full;
        w_pop           = E_Valid && !w_empty;
        w_head_pred     = r_pred[r_rptr];
        w_head_index    = r_index[r_rptr];
        w_head_target   = r_target[r_rptr];
        w_head_fallthru = r_fallthru[r_rptr];
        w_mispred       = w_pop && (w_head_pred != E_Taken);
    end

    // Storage is written on every accepted push; a flush resets the
    // pointers, so an entry written in a mispredict cycle is never read.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_pred[r_wptr]     <= F_Pred;
            r_index[r_wptr]    <= F_Index;
            r_target[r_wptr]   <= F_Target;
            r_fallthru[r_wptr] <= F_Fallthru;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset || w_mispred) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
            r_count <= r_count + (w_push ? c_CNT_ONE : '0) - (w_pop ? c_CNT_ONE : '0);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_upd_valid   <= 1'b0;
            r_flush       <= 1'b0;
            r_pred_actual <= 2'b00;
            r_upd_index   <= '0;
            r_redirect    <= '0;
            r_underflow   <= 1'b0;
        end else begin
            r_upd_valid   <= w_pop;
            r_flush       <= w_mispred;
            r_pred_actual <= w_pop ? {w_head_pred, E_Taken} : 2'b00;
            if (w_pop) begin
                r_upd_index <= w_head_index;
                r_redirect  <= E_Taken ? w_head_target : w_head_fallthru;
            end
            r_underflow   <= r_underflow || (E_Valid && w_empty);
        end
    end

`ifdef BR_RESOLVER_STATS_EN
    logic [0:15] r_branch_cnt;
    logic [0:15] r_mispred_cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_pop && r_branch_cnt != 16'hFFFF)
                r_branch_cnt <= r_branch_cnt + 16'd1;
            if (w_mispred && r_mispred_cnt != 16'hFFFF)
                r_mispred_cnt <= r_mispred_cnt + 16'd1;
        end
    end

    assign Branch_Count  = r_branch_cnt;
    assign Mispred_Count = r_mispred_cnt;
`endif

    assign F_Ready     = !w_full;
    assign Empty       = w_empty;
    assign Full        = w_full;
    assign Upd_Valid   = r_upd_valid;
    assign Flush       = r_flush;
    assign pred_actual = r_pred_actual;
    assign Upd_Index   = r_upd_index;
    assign Redirect_PC = r_redirect;
    assign Underflow   = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolver.sv
// ============================================================================
// tb_branch_resolver : scoreboard bench for branch_resolver with a queue-based
//                      reference model, directed scenarios and random traffic.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolver;

    localparam int DEPTH = 4;

    logic        Clock;
    logic        Reset;
    logic        F_Valid;
    logic        F_Pred;
    logic [3:0]  F_Index;
    logic [31:0] F_Target;
    logic [31:0] F_Fallthru;
    logic        F_Ready;
    logic        E_Valid;
    logic        E_Taken;
    logic [1:0]  pred_actual;
    logic [3:0]  Upd_Index;
    logic        Upd_Valid;
    logic        Flush;
    logic [31:0] Redirect_PC;
    logic        Empty;
    logic        Full;
    logic        Underflow;
`ifdef BR_RESOLVER_STATS_EN
    logic [15:0] Branch_Count;
    logic [15:0] Mispred_Count;
`endif

    branch_resolver #(.DEPTH(DEPTH)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .F_Valid     (F_Valid),
        .F_Pred      (F_Pred),
        .F_Index     (F_Index),
        .F_Target    (F_Target),
        .F_Fallthru  (F_Fallthru),
        .F_Ready     (F_Ready),
        .E_Valid     (E_Valid),
        .E_Taken     (E_Taken),
        .pred_actual (pred_actual),
        .Upd_Index   (Upd_Index),
        .Upd_Valid   (Upd_Valid),
        .Flush       (Flush),
        .Redirect_PC (Redirect_PC),
        .Empty       (Empty),
        .Full        (Full),
`ifdef BR_RESOLVER_STATS_EN
        .Branch_Count  (Branch_Count),
        .Mispred_Count (Mispred_Count),
`endif
        .Underflow   (Underflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc = cyc + 1;

    typedef struct {
        bit        pred;
        bit [3:0]  idx;
        bit [31:0] tgt;
        bit [31:0] ft;
    } ent_t;

    typedef struct {
        bit [1:0]  pa;
        bit [3:0]  idx;
        bit        mis;
        bit [31:0] redir;
        int        stamp;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    bit   m_under;
    int   m_bc;
    int   m_mc;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the FIFO is a plain queue; a mispredict discards it.
    task automatic model_step(input bit fv, input bit fp, input bit [3:0] fi,
                              input bit [31:0] ft, input bit [31:0] ff,
                              input bit ev, input bit et, input bit rst);
        bit   was_full;
        bit   mis;
        ent_t h;
        exp_t e;
        ent_t n;
        mis = 1'b0;
        if (rst) begin
            mq.delete();
            m_under = 1'b0;
            m_bc = 0;
            m_mc = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (ev) begin
                if (mq.size() == 0) begin
                    m_under = 1'b1;
                end else begin
                    h = mq.pop_front();
                    mis = (h.pred != et);
                    e.pa = {h.pred, et};
                    e.idx = h.idx;
                    e.mis = mis;
                    e.redir = et ? h.tgt : h.ft;
                    e.stamp = cyc;
                    sb.push_back(e);
                    if (m_bc < 65535) m_bc++;
                    if (mis && m_mc < 65535) m_mc++;
                    if (mis) mq.delete();
                end
            end
            if (fv && !was_full && !mis) begin
                n.pred = fp; n.idx = fi; n.tgt = ft; n.ft = ff;
                mq.push_back(n);
            end
        end
    endtask

    task automatic step(input bit fv, input bit fp, input bit [3:0] fi,
                        input bit [31:0] ft, input bit [31:0] ff,
                        input bit ev, input bit et, input bit rst);
        @(negedge Clock);
        check("empty",     {31'd0, Empty},     {31'd0, mq.size() == 0});
        check("full",      {31'd0, Full},      {31'd0, mq.size() == DEPTH});
        check("f_ready",   {31'd0, F_Ready},   {31'd0, mq.size() != DEPTH});
        check("underflow", {31'd0, Underflow}, {31'd0, m_under});
`ifdef BR_RESOLVER_STATS_EN
        check("branch_count",  {16'd0, Branch_Count},  m_bc);
        check("mispred_count", {16'd0, Mispred_Count}, m_mc);
`endif
        F_Valid = fv; F_Pred = fp; F_Index = fi; F_Target = ft; F_Fallthru = ff;
        E_Valid = ev; E_Taken = et; Reset = rst;
        model_step(fv, fp, fi, ft, ff, ev, et, rst);
    endtask

    task automatic idle();
        step(0, 0, 4'd0, 32'd0, 32'd0, 0, 0, 0);
    endtask

    // Monitor: compares each resolution pulse against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (Upd_Valid) begin
                if (sb.size() == 0) begin
                    check("upd_unexpected", {31'd0, Upd_Valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("upd_latency",  cyc, e.stamp + 1);
                    check("pred_actual",  {30'd0, pred_actual}, {30'd0, e.pa});
                    check("upd_index",    {28'd0, Upd_Index},   {28'd0, e.idx});
                    check("flush",        {31'd0, Flush},       {31'd0, e.mis});
                    if (e.mis) check("redirect_pc", Redirect_PC, e.redir);
                end
            end else begin
                check("idle_outputs", {29'd0, Flush, pred_actual}, 32'd0);
                if (sb.size() > 0 && sb[0].stamp + 1 <= cyc) begin
                    check("upd_missing", {31'd0, Upd_Valid}, 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        bit fv, fp, ev, et, rst;
        F_Valid = 0; F_Pred = 0; F_Index = 0; F_Target = 0; F_Fallthru = 0;
        E_Valid = 0; E_Taken = 0; Reset = 1;
        model_step(0, 0, 4'd0, 32'd0, 32'd0, 0, 0, 1);
        idle();
        check("reset_upd_index", {28'd0, Upd_Index}, 32'd0);
        check("reset_redirect",  Redirect_PC, 32'd0);
        check("reset_upd_valid", {31'd0, Upd_Valid}, 32'd0);

        // correct taken prediction
        step(1, 1, 4'd5, 32'h200, 32'h104, 0, 0, 0);
        step(0, 0, 4'd0, 32'd0, 32'd0, 1, 1, 0);
        idle();
        // predicted taken, actually not taken
        step(1, 1, 4'd9, 32'h300, 32'h104, 0, 0, 0);
        step(0, 0, 4'd0, 32'd0, 32'd0, 1, 0, 0);
        idle();
        // fill, overflow push, mispredict empties
        for (int i = 0; i < 5; i++)
            step(1, 0, 4'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i), 0, 0, 0);
        step(0, 0, 4'd0, 32'd0, 32'd0, 1, 1, 0);
        idle();
        // full: push refused even with a correct pop
        for (int i = 0; i < 4; i++)
            step(1, 1, 4'(i), 32'h40 + 32'(i), 32'h80 + 32'(i), 0, 0, 0);
        step(1, 0, 4'd7, 32'h777, 32'h778, 1, 1, 0);
        step(0, 0, 4'd0, 32'd0, 32'd0, 1, 0, 0);
        idle();
        // count 2: push + correct pop, then push + mispredict pop
        step(1, 0, 4'd1, 32'h10, 32'h14, 0, 0, 0);
        step(1, 1, 4'd2, 32'h20, 32'h24, 0, 0, 0);
        step(1, 0, 4'd3, 32'h30, 32'h34, 1, 0, 0);
        step(1, 0, 4'd4, 32'h50, 32'h54, 1, 0, 0);
        idle();
        // underflow sticky, then cleared by reset
        step(0, 0, 4'd0, 32'd0, 32'd0, 1, 1, 0);
        idle();
        idle();
        step(0, 0, 4'd0, 32'd0, 32'd0, 0, 0, 1);
        idle();
        // reset during a resolution suppresses the pulse
        step(1, 1, 4'd6, 32'h60, 32'h64, 0, 0, 0);
        step(0, 0, 4'd0, 32'd0, 32'd0, 1, 0, 1);
        idle();
        idle();

        for (int i = 0; i < 3000; i++) begin
            fv  = ($urandom_range(0, 9) < 6);
            fp  = $urandom_range(0, 1) == 1;
            ev  = ($urandom_range(0, 9) < 4);
            if (mq.size() > 0 && $urandom_range(0, 4) != 0) et = mq[0].pred;
            else et = $urandom_range(0, 1) == 1;
            rst = ($urandom_range(0, 199) == 0);
            step(fv, fp, 4'($urandom), $urandom, $urandom, ev, et, rst);
        end

        idle();
        idle();
        idle();
        check("scoreboard_drain", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter: DEPTH, 4, number of in-flight branch entries (power of two, 2..16).
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 F_Valid  input  1  fetch stage pushes a predicted branch this cycle.
REQ-005 F_Pred  input  1  prediction bit issued by the predictor for this branch (1 = taken).
REQ-006 F_Index  input  [0:3]  predictor table index of the branch (instruction bits 28..31).
REQ-007 F_Target  input  [0:31]  branch-taken target address.
REQ-008 F_Fallthru  input  [0:31]  not-taken (sequential) address.
REQ-009 F_Ready  output  1  queue can accept a push (equals not Full).
REQ-010 E_Valid  input  1  execute stage resolves the oldest in-flight branch this cycle.
REQ-011 E_Taken  input  1  actual outcome of the resolved branch (1 = taken).
REQ-012 pred_actual  output  [0:1]  {predicted, actual} of the resolved branch; drives the predictor update port.
REQ-013 Upd_Index  output  [0:3]  predictor index to update.
REQ-014 Upd_Valid  output  1  one-cycle pulse: pred_actual/Upd_Index valid.
REQ-015 Flush  output  1  one-cycle pulse: misprediction, pipeline must squash younger work.
REQ-016 Redirect_PC  output  [0:31]  correct next PC, valid while Flush is high.
REQ-017 Empty / Full  output  1 each  queue occupancy flags.
REQ-018 Underflow  output  1  sticky error: E_Valid seen while Empty.

Function
REQ-019 The block SHALL hold in-flight branches in a DEPTH-entry circular FIFO (pred, index, target, fallthru) with wrap-around read/write pointers and an occupancy counter 0..DEPTH.
REQ-020 Push SHALL occur when F_Valid and not Full; F_Valid while Full SHALL be ignored with no state change.
REQ-021 E_Valid while not Empty SHALL pop the head entry; E_Valid while Empty SHALL set Underflow and change nothing else.
REQ-022 Resolution outputs SHALL be registered: E_Valid in cycle n drives Upd_Valid, pred_actual, Upd_Index, Flush, Redirect_PC in cycle n+1, each pulse one cycle long.
REQ-023 pred_actual SHALL equal {head.pred, E_Taken}: 00/11 correct, 01 predicted not-taken/actually taken, 10 predicted taken/actually not-taken.
REQ-024 Flush SHALL assert when pred_actual is 01 or 10; Redirect_PC SHALL be head.target if E_Taken else head.fallthru.
REQ-025 On mispredict the FIFO SHALL be emptied (all younger entries are wrong-path) in the same edge as the pop; a simultaneous push in that cycle SHALL be discarded.
REQ-026 Simultaneous push and correct-prediction pop SHALL both take effect, leaving the count unchanged; when Full, the push is still refused (F_Ready is count-based).
REQ-027 When no resolution occurs, Upd_Valid and Flush SHALL be 0, pred_actual 00, Redirect_PC holds its last value.

Reset
REQ-028 Reset SHALL clear pointers and count, giving Empty=1, Full=0, F_Ready=1, Upd_Valid=0, Flush=0, pred_actual=00, Upd_Index=0, Redirect_PC=0, Underflow=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries and suppress any pending resolution pulse in the following cycle.

Configuration
REQ-030 With BR_RESOLVER_STATS_EN defined, the block SHALL add outputs Branch_Count [0:15] and Mispred_Count [0:15], incremented per resolution / per Flush, saturating at 16'hFFFF, cleared by Reset.
REQ-031 Without BR_RESOLVER_STATS_EN the counters and ports SHALL be absent and behaviour otherwise identical.

Verification
REQ-032 Reset, push F_Pred=1,F_Index=5, then E_Valid,E_Taken=1 -> next cycle Upd_Valid=1, pred_actual=11, Upd_Index=5, Flush=0, Empty=1.
REQ-033 Push F_Pred=1,F_Fallthru=32'h104; resolve E_Taken=0 -> pred_actual=10, Flush=1, Redirect_PC=32'h104.
REQ-034 Push 4 branches (DEPTH=4), 5th F_Valid -> Full=1, F_Ready=0, 5th ignored; first resolve mispredicts -> Empty=1 next cycle.
REQ-035 Count=2, push and correct-prediction pop in same cycle -> count stays 2; same with mispredict -> Empty=1, push dropped.
REQ-036 E_Valid while Empty -> Underflow=1 sticky, Upd_Valid=0; Reset clears it; with BR_RESOLVER_STATS_EN, 3 resolutions incl. 1 mispredict -> Branch_Count=3, Mispred_Count=1.
